// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-low seven-segment bus and
// recovers the hex value shown on each digit. A sample must be seen unchanged
// and with exactly one digit selected STABLE times in a row before it is
// committed; each steady run commits once.
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_n,
  input  logic              err_clr,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   blank,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err,
  output logic [2:0]        err_idx
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

  // capture register (s) and the sample before it (p)
  logic [6:0]      seg_s_reg, seg_p_reg;
  logic [NDIG-1:0] dig_s_reg, dig_p_reg;
  logic            s_vld_reg;

  // run tracking
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            done_reg, done_next;
  logic            done_eff;
  logic            s_legal, s_same, commit;

  // selected digit and glyph decode of the captured sample
  logic [2:0]      sel_idx;
  logic            glyph_ok, glyph_blk;
  logic [3:0]      glyph_val;

  // commit-side registers
  logic            upd_reg;
  logic [2:0]      upd_idx_reg;
  logic            err_reg;
  logic [2:0]      err_idx_reg;

  // Register the pins every edge; s_vld_reg masks the cleared value after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s_reg <= '0;
      dig_s_reg <= '0;
      seg_p_reg <= '0;
      dig_p_reg <= '0;
      s_vld_reg <= 1'b0;
    end else begin
      seg_p_reg <= seg_s_reg;
      dig_p_reg <= dig_s_reg;
      seg_s_reg <= seg_n;
      dig_s_reg <= dig_n;
      s_vld_reg <= 1'b1;
    end
  end

  // Run counter next state and commit decision for the captured sample.
  always_comb begin
    s_legal   = s_vld_reg && $onehot(~dig_s_reg);
    s_same    = (seg_s_reg == seg_p_reg) && (dig_s_reg == dig_p_reg);
    cnt_next  = '0;
    done_eff  = 1'b0;
    if (s_legal) begin
      if (s_same) begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        done_eff = done_reg;
      end else begin
        cnt_next = CW'(1);
      end
    end
    commit    = s_legal && (cnt_next == CNT_MAX) && !done_eff;
    done_next = commit ? 1'b1 : done_eff;
  end

  // Run counter and commit-once flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  // Index of the single active-low digit select in the captured sample.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!dig_s_reg[i]) sel_idx = 3'(i);
    end
  end

  // Glyph lookup: hex value, all-off blank, or not a glyph.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_blk = 1'b0;
    glyph_val = 4'h0;
    case (seg_s_reg)
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h10: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      7'h7F: begin
        glyph_ok  = 1'b0;
        glyph_blk = 1'b1;
      end
      default: glyph_ok = 1'b0;
    endcase
  end

  // Commit pulse, its index, and the sticky error (a new error beats err_clr).
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_reg     <= 1'b0;
      upd_idx_reg <= 3'd0;
      err_reg     <= 1'b0;
      err_idx_reg <= 3'd0;
    end else begin
      upd_reg     <= commit;
      upd_idx_reg <= commit ? sel_idx : 3'd0;
      if (commit && !glyph_ok && !glyph_blk) begin
        err_reg     <= 1'b1;
        err_idx_reg <= sel_idx;
      end else if (err_clr) begin
        err_reg     <= 1'b0;
        err_idx_reg <= 3'd0;
      end
    end
  end

  // Per-digit result registers, updated only when a commit targets that digit.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    logic [3:0] val_reg;
    logic       vld_reg;
    logic       blk_reg;

    // Hold the last decoded value; valid/blank reflect the latest commit.
    always_ff @(posedge clk) begin
      if (reset) begin
        val_reg <= 4'h0;
        vld_reg <= 1'b0;
        blk_reg <= 1'b0;
      end else if (commit && (sel_idx == 3'(gi))) begin
        if (glyph_ok) begin
          val_reg <= glyph_val;
          vld_reg <= 1'b1;
          blk_reg <= 1'b0;
        end else begin
          vld_reg <= 1'b0;
          blk_reg <= glyph_blk;
        end
      end
    end

    assign digits[4*gi +: 4] = val_reg;
    assign valid[gi]         = vld_reg;
    assign blank[gi]         = blk_reg;
  end

  assign upd     = upd_reg;
  assign upd_idx = upd_idx_reg;
  assign err     = err_reg;
  assign err_idx = err_idx_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scenarios plus randomized display traffic,
// checked every cycle against a history-based model of the decoder.
module tb_seg7_scan_decoder;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic              clk;
  logic              reset;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   dig_n;
  logic              err_clr;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   valid;
  logic [NDIG-1:0]   blank;
  logic              upd;
  logic [2:0]        upd_idx;
  logic              err;
  logic [2:0]        err_idx;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  // model state
  logic [11:0] hist[$];
  logic [3:0]  m_dig [NDIG];
  logic [NDIG-1:0] m_valid, m_blank;
  logic        m_upd, m_err;
  logic [2:0]  m_upd_idx, m_err_idx;
  bit          started = 0;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .dig_n(dig_n), .err_clr(err_clr),
    .digits(digits), .valid(valid), .blank(blank), .upd(upd), .upd_idx(upd_idx),
    .err(err), .err_idx(err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // one cycle: drive on the falling edge, return just after the rising edge
  task automatic cyc(input logic [6:0] s, input logic [3:0] d, input logic clr, input logic rst);
    @(negedge clk);
    seg_n = s; dig_n = d; err_clr = clr; reset = rst;
    @(posedge clk);
    #1;
    if (upd) upd_cnt++;
  endtask

  // Model: a commit happens exactly when the most recent run of identical,
  // legal samples has just reached length STABLE.
  initial begin
    logic [11:0] last;
    logic [3:0]  dsel;
    logic [6:0]  gseg;
    int          run;
    int          idx;
    int          val;
    bit          commit, found, bad;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < NDIG; i++) m_dig[i] = 4'h0;
        m_valid = '0; m_blank = '0; m_upd = 1'b0; m_upd_idx = 3'd0;
        m_err = 1'b0; m_err_idx = 3'd0;
        hist.push_back(12'h000);
        started = 1;
      end else begin
        run = 0;
        if (hist.size() > 0) begin
          last = hist[hist.size()-1];
          dsel = last[10:7];
          if (last[11] && $countones(dsel) == NDIG - 1) begin
            for (int k = hist.size() - 1; k >= 0; k--) begin
              if (hist[k] == last) run++;
              else break;
            end
          end
        end
        commit = (run == STABLE);
        bad = 0;
        idx = 0;
        if (commit) begin
          for (int i = 0; i < NDIG; i++) if (!dsel[i]) idx = i;
          gseg = last[6:0];
          found = 0; val = 0;
          for (int v = 0; v < 16; v++) if (GLYPH[v] == gseg) begin found = 1; val = v; end
          if (found) begin
            m_dig[idx] = 4'(val); m_valid[idx] = 1'b1; m_blank[idx] = 1'b0;
          end else if (gseg == 7'h7F) begin
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b1;
          end else begin
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; bad = 1;
          end
        end
        if (bad) begin
          m_err = 1'b1; m_err_idx = 3'(idx);
        end else if (err_clr) begin
          m_err = 1'b0; m_err_idx = 3'd0;
        end
        m_upd = commit;
        m_upd_idx = commit ? 3'(idx) : 3'd0;
        hist.push_back({1'b1, dig_n, seg_n});
      end
      if (hist.size() > 32) void'(hist.pop_front());
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [31:0] got, exp;
    forever begin
      @(negedge clk);
      if (started) begin
        got = {digits, valid, blank, upd, upd_idx, err, err_idx};
        exp = {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_blank,
               m_upd, m_upd_idx, m_err, m_err_idx};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle_cmp got=%h expected=%h t=%0t", got, exp, $time);
        end
      end
    end
  end

  initial begin
    int c0, len, r;
    logic [6:0] s;
    logic [3:0] d;
    reset = 1'b1; seg_n = 7'h7F; dig_n = 4'hF; err_clr = 1'b0;

    repeat (3) cyc(7'h7F, 4'hF, 1'b0, 1'b1);
    chk("reset_outputs", {digits, valid, blank, upd, upd_idx, err, err_idx}, 32'h0);

    // steady "3" on digit 0: one commit, three edges after the first sample
    c0 = upd_cnt;
    for (int i = 0; i < 5; i++) begin
      cyc(7'h30, 4'b1110, 1'b0, 1'b0);
      chk($sformatf("t1_upd_%0d", i), {31'd0, upd}, {31'd0, (i == 3)});
    end
    chk("t1_count", upd_cnt - c0, 1);
    chk("t1_digit0", {28'd0, digits[3:0]}, 32'h3);
    chk("t1_valid", {28'd0, valid}, 32'b0001);

    // all 16 glyphs on digit 2
    c0 = upd_cnt;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(GLYPH[k], 4'b1011, 1'b0, 1'b0);
        if (j == 3)
          chk($sformatf("t2_glyph_%0d", k), {24'd0, upd, upd_idx, digits[11:8]},
              {24'd0, 1'b1, 3'd2, 4'(k)});
      end
    end
    chk("t2_count", upd_cnt - c0, 16);
    chk("t2_err", {31'd0, err}, 32'd0);

    // short "0" glitch then steady "1" on digit 0
    c0 = upd_cnt;
    repeat (2) cyc(7'h40, 4'b1110, 1'b0, 1'b0);
    repeat (4) cyc(7'h79, 4'b1110, 1'b0, 1'b0);
    chk("t3_count", upd_cnt - c0, 1);
    chk("t3_digit0", {28'd0, digits[3:0]}, 32'h1);

    // illegal selects never commit
    c0 = upd_cnt;
    repeat (10) cyc(7'h30, 4'b1111, 1'b0, 1'b0);
    repeat (10) cyc(7'h30, 4'b1100, 1'b0, 1'b0);
    chk("t4_count", upd_cnt - c0, 0);
    chk("t4_state", {digits, valid, blank}, {16'h0F01, 4'b0101, 4'b0000});

    // digit 1: "2", then blank, then a non-glyph
    repeat (4) cyc(7'h24, 4'b1101, 1'b0, 1'b0);
    repeat (4) cyc(7'h7F, 4'b1101, 1'b0, 1'b0);
    chk("t5_blank", {valid, blank, 7'd0, err}, {4'b0101, 4'b0010, 7'd0, 1'b0});
    repeat (4) cyc(7'h55, 4'b1101, 1'b0, 1'b0);
    chk("t5_illegal", {valid, blank, err, err_idx, digits[7:4]},
        {4'b0101, 4'b0000, 1'b1, 3'd1, 4'h2});
    // err_clr coinciding with a new illegal commit on digit 3
    repeat (3) cyc(7'h55, 4'b0111, 1'b0, 1'b0);
    cyc(7'h55, 4'b0111, 1'b1, 1'b0);
    chk("t5_set_wins", {28'd0, upd, err, err_idx[1:0]}, {28'd0, 1'b1, 1'b1, 2'd3});
    cyc(7'h7F, 4'b1111, 1'b1, 1'b0);
    chk("t5_clear", {28'd0, err, err_idx}, 32'd0);

    // reset in the middle of a run
    repeat (3) cyc(7'h12, 4'b1110, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(7'h12, 4'b1110, 1'b0, 1'b1);
      chk($sformatf("t6_reset_%0d", i), {digits, valid, blank, upd, upd_idx, err, err_idx}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(7'h12, 4'b1110, 1'b0, 1'b0);
      chk($sformatf("t6_upd_%0d", i), {31'd0, upd}, {31'd0, (i == 3)});
    end
    chk("t6_result", {20'd0, digits[3:0], valid, blank}, {20'd0, 4'h5, 4'b0001, 4'b0000});

    // randomized display traffic
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6) s = GLYPH[$urandom_range(0, 15)];
      else if (r < 8) s = 7'h7F;
      else s = 7'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) d = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 8) d = 4'hF;
      else d = 4'($urandom);
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++)
        cyc(s, d, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end

    repeat (2) cyc(7'h7F, 4'hF, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
